// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with one full-adder cell, registered carry and start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0] cnt;
    logic carry, s, c_nxt, load, last;
    always_comb begin
        s = a_sr[0] ^ b_sr[0] ^ carry;
        c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        load = start && state != SHIFT;
        last = cnt == LAST;
        state_nxt = load ? SHIFT : state != SHIFT ? IDLE : last ? DONE : SHIFT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr <= '0;
            b_sr <= '0;
            acc <= '0;
            cnt <= '0;
            carry <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr <= a;
                b_sr <= b;
                carry <= cin;
                cnt <= '0;
                acc <= '0;
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                carry <= c_nxt;
                acc <= (acc >> 1) | ((WIDTH-1)'(s) << (WIDTH - 2));
                cnt <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    sum <= {s, acc};
                    cout <= c_nxt;
                end
            end
        end
    end
    assign busy = state == SHIFT;
    assign done = state == DONE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder against plain a+b+cin arithmetic
module tb_serial_adder;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic cin = 1'b0;
    logic busy, done, cout;
    logic [W-1:0] sum;
    logic [W:0] sb[$];
    logic [W:0] last_res = '0;
    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("result", 32'({cout, sum}), 32'(sb.pop_front()));
        end
    end

    task automatic scramble();
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        int n;
        logic [W:0] e;
        e = model(ta, tb_, tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < W + 2) begin
            chk("hold_prev", 32'({cout, sum}), 32'(last_res));
            n++;
            scramble();
            @(negedge clk);
        end
        chk("busy_len", n, W);
        chk("done_pulse", 32'(done), 32'd1);
        last_res = e;
    endtask

    initial begin
        int dcount;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_res", 32'({cout, sum}), 0);
        rst = 1'b0;
        run_add(8'd100, 8'd27, 1'b0);
        chk("dir_100_27", 32'(last_res), 32'h07F);
        run_add(8'hFF, 8'h01, 1'b0);
        chk("dir_ripple", 32'(last_res), 32'h100);
        run_add(8'h5A, 8'hA5, 1'b1);
        run_add(8'h00, 8'h00, 1'b0);
        // start held high: accepts every W+1 edges, operands churn each cycle
        for (int k = 0; k < 3 * (W + 1); k++) begin
            @(negedge clk);
            if (k > 0) chk("b2b_done", 32'(done), 32'((k - 1) % (W + 1) == W));
            start = 1'b1;
            scramble();
            if (k % (W + 1) == 0) begin
                sb.push_back(model(a, b, cin));
                last_res = model(a, b, cin);
            end
        end
        @(negedge clk);
        chk("b2b_done_last", 32'(done), 1);
        start = 1'b0;
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_res", 32'({cout, sum}), 0);
        last_res = '0;
        dcount = 0;
        repeat (W + 4) begin
            @(negedge clk);
            dcount += int'(done) + int'(busy);
        end
        chk("abort_quiet", dcount, 0);
        run_add(8'd3, 8'd4, 1'b0);
        chk("after_abort", 32'(last_res), 32'h007);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd6;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", 32'(busy), 0);
        last_res = '0;
        dcount = 0;
        repeat (W + 4) begin
            @(negedge clk);
            dcount += int'(done) + int'(busy);
        end
        chk("rst_wins_quiet", dcount, 0);
        chk("rst_wins_res", 32'({cout, sum}), 0);
        for (int i = 0; i < 16; i++) run_add(W'($urandom), W'($urandom), 1'($urandom));
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
